// File: rtl/cmd_issue_queue_pkg.sv
// usertype: shared command/tag types for the DDR3 command issue front-end.
//   user_command_type_t : host command word (USER_COMMAND_BITS wide)
//   issue_tag_t         : {rank, bank, row, col} attached to each read response
//   CQ_DEPTH_DEF / TAG_DEPTH_DEF : default depths of the command and tag FIFOs
package usertype;

    localparam int RANK_BITS = 2;
    localparam int BA_BITS   = 3;
    localparam int ROW_BITS  = 16;
    localparam int COL_BITS  = 10;

    localparam int USER_COMMAND_BITS = 34;
    localparam int CQ_DEPTH_DEF      = 8;
    localparam int TAG_DEPTH_DEF     = 16;

    // r_w: 1 = read, 0 = write. ap/bc are passed through untouched.
    typedef struct packed {
        logic                 r_w;
        logic [RANK_BITS-1:0] rank_num;
        logic [BA_BITS-1:0]   bank_addr;
        logic [ROW_BITS-1:0]  row_addr;
        logic [COL_BITS-1:0]  col_addr;
        logic                 ap;
        logic                 bc;
    } user_command_type_t;

    typedef struct packed {
        logic [RANK_BITS-1:0] rank_num;
        logic [BA_BITS-1:0]   bank_addr;
        logic [ROW_BITS-1:0]  row_addr;
        logic [COL_BITS-1:0]  col_addr;
    } issue_tag_t;

endpackage

// File: rtl/cmd_issue_queue_fifo.sv
// cmd_sync_fifo: single-clock FIFO, async active-high reset.
//   push/wdata : write when not full (push while full is ignored)
//   pop/rdata  : rdata is the current head (combinational); pop ignored when empty
//   full/empty/count : derived from registered pointers only
// Pointers carry one extra bit so full and empty are distinguishable.
module cmd_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign count = wr_ptr_q - rd_ptr_q;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; flushing the pointers is enough to discard it.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cmd_issue_queue.sv
// cmd_issue_queue: in-order command buffer in front of the DDR3 controller.
//   host_*     : valid/ready command+write-data input (host_ready registered)
//   command/valid/write_data : one-cycle registered issue strobe to controller
//   ba_cmd_pm  : per-bank permission; head issues only if its bank bit is set
//   read_data/read_data_valid : read beats from the controller
//   rsp_*      : read beats tagged with the {rank,bank,row,col} of their read
//   rd_outstanding : reads issued and not yet returned
//   rsp_err    : sticky, a beat arrived with no read outstanding
module cmd_issue_queue
    import usertype::*;
#(
    parameter int CMD_W     = USER_COMMAND_BITS,
    parameter int DATA_W    = 128,
    parameter int CQ_DEPTH  = CQ_DEPTH_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          power_on_rst,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic [CMD_W-1:0]              host_cmd,
    input  logic [DATA_W-1:0]             host_wdata,
    output logic [CMD_W-1:0]              command,
    output logic                          valid,
    output logic [DATA_W-1:0]             write_data,
    input  logic [7:0]                    ba_cmd_pm,
    input  logic [DATA_W-1:0]             read_data,
    input  logic                          read_data_valid,
    output logic                          rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic [$bits(issue_tag_t)-1:0] rsp_tag,
    output logic [$clog2(TAG_DEPTH):0]    rd_outstanding,
    output logic                          rsp_err
);
    localparam int CQW  = $clog2(CQ_DEPTH);
    localparam int TAGW = $bits(issue_tag_t);

    // Command queue
    logic [CMD_W+DATA_W-1:0] cq_rdata;
    logic                    cq_push, cq_pop, cq_full, cq_empty;
    logic [CQW:0]            cq_count, cq_count_nxt;
    user_command_type_t      head_cmd;
    logic [DATA_W-1:0]       head_wdata;

    // Tag FIFO
    issue_tag_t              tag_wdata, tag_rdata;
    logic                    tag_push, tag_pop, tag_full, tag_empty;

    logic                    issue;

    // Output registers
    logic                    host_ready_q, host_ready_d;
    logic                    valid_q, valid_d;
    logic [CMD_W-1:0]        command_q, command_d;
    logic [DATA_W-1:0]       write_data_q, write_data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
    logic [TAGW-1:0]         rsp_tag_q, rsp_tag_d;
    logic                    rsp_err_q, rsp_err_d;

    assign head_cmd   = user_command_type_t'(cq_rdata[CMD_W+DATA_W-1 -: CMD_W]);
    assign head_wdata = cq_rdata[DATA_W-1:0];

    // A read only issues if its tag has somewhere to go; the tag FIFO's full
    // flag is registered, so a same-edge beat pop does not free a slot early.
    assign issue = !cq_empty && ba_cmd_pm[head_cmd.bank_addr] &&
                   (!head_cmd.r_w || !tag_full);

    assign cq_push  = host_valid && host_ready_q && !cq_full;
    assign cq_pop   = issue;
    assign tag_push = issue && head_cmd.r_w;
    assign tag_pop  = read_data_valid && !tag_empty;

    always_comb begin
        tag_wdata           = '0;
        tag_wdata.rank_num  = head_cmd.rank_num;
        tag_wdata.bank_addr = head_cmd.bank_addr;
        tag_wdata.row_addr  = head_cmd.row_addr;
        tag_wdata.col_addr  = head_cmd.col_addr;
    end

    // host_ready is the registered "not full" of the occupancy after this edge.
    always_comb begin
        cq_count_nxt = cq_count + (CQW+1)'(cq_push) - (CQW+1)'(cq_pop);
        host_ready_d = (cq_count_nxt != (CQW+1)'(CQ_DEPTH));
    end

    always_comb begin
        valid_d      = issue;
        command_d    = issue ? CMD_W'(head_cmd) : '0;
        write_data_d = (issue && !head_cmd.r_w) ? head_wdata : '0;
        rsp_valid_d  = tag_pop;
        rsp_data_d   = tag_pop ? read_data : rsp_data_q;
        rsp_tag_d    = tag_pop ? TAGW'(tag_rdata) : rsp_tag_q;
        rsp_err_d    = rsp_err_q || (read_data_valid && tag_empty);
    end

    always_ff @(posedge clk or posedge power_on_rst) begin
        if (power_on_rst) begin
            host_ready_q <= 1'b0;
            valid_q      <= 1'b0;
            command_q    <= '0;
            write_data_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_tag_q    <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            host_ready_q <= host_ready_d;
            valid_q      <= valid_d;
            command_q    <= command_d;
            write_data_q <= write_data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_tag_q    <= rsp_tag_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    cmd_sync_fifo #(.WIDTH(CMD_W+DATA_W), .DEPTH(CQ_DEPTH)) u_cmd_q (
        .clk   (clk),
        .rst   (power_on_rst),
        .push  (cq_push),
        .wdata ({host_cmd, host_wdata}),
        .pop   (cq_pop),
        .rdata (cq_rdata),
        .full  (cq_full),
        .empty (cq_empty),
        .count (cq_count)
    );

    cmd_sync_fifo #(.WIDTH(TAGW), .DEPTH(TAG_DEPTH)) u_tag_q (
        .clk   (clk),
        .rst   (power_on_rst),
        .push  (tag_push),
        .wdata (tag_wdata),
        .pop   (tag_pop),
        .rdata (tag_rdata),
        .full  (tag_full),
        .empty (tag_empty),
        .count (rd_outstanding)
    );

    assign host_ready = host_ready_q;
    assign valid      = valid_q;
    assign command    = command_q;
    assign write_data = write_data_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_tag    = rsp_tag_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_cmd_issue_queue.sv
module tb_cmd_issue_queue;
    import usertype::*;

    logic               clk = 1'b0;
    logic               power_on_rst = 1'b1;
    logic               host_valid = 1'b0;
    logic               host_ready;
    user_command_type_t host_cmd = '0;
    logic [127:0]       host_wdata = '0;
    logic [33:0]        command;
    logic               valid;
    logic [127:0]       write_data;
    logic [7:0]         ba_cmd_pm = 8'h00;
    logic [127:0]       read_data = '0;
    logic               read_data_valid = 1'b0;
    logic               rsp_valid;
    logic [127:0]       rsp_data;
    logic [30:0]        rsp_tag;
    logic [4:0]         rd_outstanding;
    logic               rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cmd_issue_queue dut (
        .clk             (clk),
        .power_on_rst    (power_on_rst),
        .host_valid      (host_valid),
        .host_ready      (host_ready),
        .host_cmd        (host_cmd),
        .host_wdata      (host_wdata),
        .command         (command),
        .valid           (valid),
        .write_data      (write_data),
        .ba_cmd_pm       (ba_cmd_pm),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .rsp_tag         (rsp_tag),
        .rd_outstanding  (rd_outstanding),
        .rsp_err         (rsp_err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic user_command_type_t mkcmd(input logic rw, input logic [1:0] rank,
                                                 input logic [2:0] bank, input logic [15:0] row,
                                                 input logic [9:0] col);
        user_command_type_t c;
        c = '0;
        c.r_w = rw; c.rank_num = rank; c.bank_addr = bank; c.row_addr = row; c.col_addr = col;
        return c;
    endfunction

    function automatic issue_tag_t tagof(input user_command_type_t c);
        issue_tag_t t;
        t.rank_num = c.rank_num; t.bank_addr = c.bank_addr;
        t.row_addr = c.row_addr; t.col_addr = c.col_addr;
        return t;
    endfunction

    task automatic do_reset();
        power_on_rst = 1'b1;
        host_valid = 1'b0; host_cmd = '0; host_wdata = '0;
        read_data_valid = 1'b0; read_data = '0; ba_cmd_pm = 8'h00;
        tick(); tick();
        power_on_rst = 1'b0;
        tick();
    endtask

    typedef struct {
        logic         rw;
        logic [2:0]   bank;
        logic [15:0]  row;
        logic [9:0]   col;
        logic [127:0] wdata;
        logic [7:0]   pm;
        logic         exp_valid;
    } vec_t;

    vec_t               vt[6];
    user_command_type_t c, ca, cb;
    user_command_type_t rds[17];
    logic               any_v;
    logic [127:0]       exp_wd;
    int                 w;

    initial begin
        vt[0] = '{1'b0, 3'd0, 16'd5,   10'd8,   {16{8'hA5}},     8'h01, 1'b1};
        vt[1] = '{1'b0, 3'd3, 16'd77,  10'd12,  128'h1234_5678,  8'h08, 1'b1};
        vt[2] = '{1'b0, 3'd3, 16'd77,  10'd12,  128'hDEAD,       8'hF7, 1'b0};
        vt[3] = '{1'b1, 3'd7, 16'hBEEF,10'd1023,128'hFFFF,       8'h80, 1'b1};
        vt[4] = '{1'b1, 3'd1, 16'd9,   10'd3,   128'h0,          8'hFD, 1'b0};
        vt[5] = '{1'b1, 3'd5, 16'd42,  10'd64,  128'h55AA,       8'hFF, 1'b1};

        // Reset state
        tick();
        chk("rst_host_ready", host_ready, 0);
        chk("rst_valid", valid, 0);
        chk("rst_command", command, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_tag", rsp_tag, 0);
        chk("rst_rd_outstanding", rd_outstanding, 0);
        chk("rst_rsp_err", rsp_err, 0);
        power_on_rst = 1'b0;
        tick();
        chk("rst_release_ready", host_ready, 1);

        // Single-command vectors: push at edge N, expect the strobe after N+1
        for (int i = 0; i < 6; i++) begin
            do_reset();
            c = mkcmd(vt[i].rw, 2'd0, vt[i].bank, vt[i].row, vt[i].col);
            ba_cmd_pm = vt[i].pm;
            host_cmd = c; host_wdata = vt[i].wdata; host_valid = 1'b1;
            tick();
            host_valid = 1'b0;
            chk($sformatf("vec%0d_valid_at_N", i), valid, 0);
            tick();
            exp_wd = (vt[i].exp_valid && !vt[i].rw) ? vt[i].wdata : 128'h0;
            chk($sformatf("vec%0d_valid", i), valid, vt[i].exp_valid);
            chk($sformatf("vec%0d_command", i), command, vt[i].exp_valid ? 34'(c) : 34'h0);
            chk($sformatf("vec%0d_write_data", i), write_data, exp_wd);
            tick();
            chk($sformatf("vec%0d_valid_one_cycle", i), valid, 0);
            if (vt[i].rw && vt[i].exp_valid) begin
                chk($sformatf("vec%0d_rd_out", i), rd_outstanding, 1);
                read_data_valid = 1'b1; read_data = vt[i].wdata ^ 128'hF0F0;
                tick();
                read_data_valid = 1'b0;
                chk($sformatf("vec%0d_rsp_valid", i), rsp_valid, 1);
                chk($sformatf("vec%0d_rsp_tag", i), rsp_tag, 31'(tagof(c)));
                chk($sformatf("vec%0d_rsp_data", i), rsp_data, vt[i].wdata ^ 128'hF0F0);
                chk($sformatf("vec%0d_rd_out_after", i), rd_outstanding, 0);
            end
        end

        // Reset mid-operation discards queued writes
        do_reset();
        host_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            host_cmd = mkcmd(1'b0, 2'd0, 3'(i), 16'(i), 10'd0); host_wdata = 128'(i + 1);
            tick();
        end
        host_valid = 1'b0;
        chk("midrst_ready_before", host_ready, 1);
        #2 power_on_rst = 1'b1;
        #1;
        chk("midrst_async_ready", host_ready, 0);
        chk("midrst_async_valid", valid, 0);
        tick();
        power_on_rst = 1'b0;
        ba_cmd_pm = 8'hFF;
        any_v = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            any_v |= valid;
        end
        chk("midrst_no_issue", any_v, 0);
        chk("midrst_ready_after", host_ready, 1);

        // Blocked head stalls a ready command behind it
        do_reset();
        ba_cmd_pm = 8'h01;
        ca = mkcmd(1'b0, 2'd1, 3'd2, 16'd20, 10'd4);
        cb = mkcmd(1'b0, 2'd0, 3'd0, 16'd30, 10'd5);
        host_valid = 1'b1;
        host_cmd = ca; host_wdata = 128'hAAAA; tick();
        host_cmd = cb; host_wdata = 128'hBBBB; tick();
        host_valid = 1'b0;
        any_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            any_v |= valid;
        end
        chk("blk_stalled", any_v, 0);
        ba_cmd_pm = 8'h05;
        tick();
        chk("blk_first_valid", valid, 1);
        chk("blk_first_cmd", command, 34'(ca));
        chk("blk_first_wd", write_data, 128'hAAAA);
        tick();
        chk("blk_second_valid", valid, 1);
        chk("blk_second_cmd", command, 34'(cb));
        chk("blk_second_wd", write_data, 128'hBBBB);
        tick();
        chk("blk_idle", valid, 0);

        // Full queue: 8 accepted, 9th refused, then drain in order
        do_reset();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("full_ready_%0d", i), host_ready, 1);
            host_cmd = mkcmd(1'b0, 2'd0, 3'd3, 16'(100 + i), 10'(i));
            host_wdata = 128'(i + 1); host_valid = 1'b1;
            tick();
        end
        chk("full_ready_after8", host_ready, 0);
        host_cmd = mkcmd(1'b0, 2'd0, 3'd3, 16'd200, 10'd0); host_wdata = 128'h99;
        tick(); tick();
        chk("full_ready_hold", host_ready, 0);
        host_valid = 1'b0;
        ba_cmd_pm = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("full_issue%0d_valid", i), valid, 1);
            chk($sformatf("full_issue%0d_cmd", i), command,
                34'(mkcmd(1'b0, 2'd0, 3'd3, 16'(100 + i), 10'(i))));
            chk($sformatf("full_issue%0d_wd", i), write_data, 128'(i + 1));
        end
        tick();
        chk("full_no_ninth", valid, 0);
        chk("full_ready_end", host_ready, 1);

        // 17 reads: 16 fill the tag FIFO, the 17th waits for a free tag
        do_reset();
        ba_cmd_pm = 8'hFF;
        for (int i = 0; i < 17; i++) begin
            rds[i] = mkcmd(1'b1, 2'd1, 3'(i % 8), (i < 16) ? 16'(i) : 16'd99, 10'd0);
            host_cmd = rds[i]; host_valid = 1'b1;
            w = 0;
            while (!host_ready && w < 50) begin
                tick();
                w++;
            end
            if (w >= 50) chk("rd_push_timeout", 1, 0);
            tick();
        end
        host_valid = 1'b0;
        repeat (4) tick();
        chk("rd_out_full", rd_outstanding, 16);
        chk("rd_stalled", valid, 0);
        for (int i = 0; i < 17; i++) begin
            read_data_valid = 1'b1; read_data = 128'(1000 + i);
            tick();
            chk($sformatf("rd_beat%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("rd_beat%0d_tag", i), rsp_tag, 31'(tagof(rds[i])));
            chk($sformatf("rd_beat%0d_data", i), rsp_data, 128'(1000 + i));
            chk($sformatf("rd_beat%0d_issue", i), valid, (i == 1) ? 1 : 0);
            chk($sformatf("rd_beat%0d_out", i), rd_outstanding, (i == 0) ? 15 : 16 - i);
        end
        read_data_valid = 1'b0;
        tick();
        chk("rd_idle_rsp_valid", rsp_valid, 0);
        chk("rd_idle_tag_hold", rsp_tag, 31'(tagof(rds[16])));
        chk("rd_idle_data_hold", rsp_data, 128'd1016);
        chk("rd_err_clear", rsp_err, 0);

        // Spurious beat with nothing outstanding
        do_reset();
        read_data_valid = 1'b1; read_data = 128'd77;
        tick();
        read_data_valid = 1'b0;
        chk("spur_rsp_valid", rsp_valid, 0);
        chk("spur_rsp_err", rsp_err, 1);
        chk("spur_rsp_data", rsp_data, 0);
        repeat (3) tick();
        chk("spur_err_sticky", rsp_err, 1);
        power_on_rst = 1'b1;
        #1;
        chk("spur_err_reset", rsp_err, 0);
        tick();
        power_on_rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_issue_queue.md
Name: cmd_issue_queue

Overview:
- Front-end stage directly upstream of the DDR3 controller. It accepts user commands and write data from a host over a valid/ready handshake and buffers them in order.
- Issues the head command to the controller only when that bank's ba_cmd_pm bit is set.
- Tracks outstanding reads and tags each returned read beat with its rank/bank/row/col.
- Replaces the ad-hoc command-table driver used in simulation with synthesizable logic.

Parameters:
- CMD_W, 34, width of user_command_type_t (`USER_COMMAND_BITS).
- DATA_W, 128, write/read data width (DQ_BITS*8).
- CQ_DEPTH, 8, command/wdata FIFO depth; power of 2, at least 2.
- TAG_DEPTH, 16, max outstanding reads; power of 2, at least 2.

Ports:
- clk, in, 1, single system clock; all logic on posedge.
- power_on_rst, in, 1, asynchronous active-high reset.
- host_valid, in, 1, host command valid.
- host_ready, out, 1, queue can accept; equals !cq_full, registered.
- host_cmd, in, CMD_W, user_command_type_t.
- host_wdata, in, DATA_W, write data; ignored for reads.
- command, out, CMD_W, command to controller.
- valid, out, 1, command strobe, one cycle per command.
- write_data, out, DATA_W, data paired with a write command, else 0.
- ba_cmd_pm, in, 8, per-bank "may accept command" from controller.
- read_data, in, DATA_W, read beat from controller.
- read_data_valid, in, 1, read beat strobe.
- rsp_valid, out, 1, tagged read response strobe.
- rsp_data, out, DATA_W, response data.
- rsp_tag, out, $bits(issue_tag_t), {rank, bank, row, col} of the response.
- rd_outstanding, out, $clog2(TAG_DEPTH)+1, reads issued but not yet returned.
- rsp_err, out, 1, sticky; a read beat arrived with the tag FIFO empty.

Behaviour:
- Reset (async, any time, including mid-burst): both FIFOs flushed; host_ready=0 while power_on_rst is high, then 1 from the first posedge after deassertion. valid=0, command=0, write_data=0, rsp_valid=0, rsp_data=0, rsp_tag=0, rd_outstanding=0, rsp_err=0. In-flight data is discarded.
- Accept: host_valid && host_ready at edge N pushes {cmd, wdata} into the command queue. host_ready depends only on registered occupancy. A full queue rejects even if a pop happens in the same cycle (no bypass).
- Issue decision (combinational, evaluated in the cycle before an edge): cq not empty, ba_cmd_pm[head.bank_addr]==1, and if head.r_w==1 the tag FIFO is not full.
  - On the edge, the head is popped and the outputs are registered: command=head, valid=1, write_data = (r_w==0) ? head wdata : 0.
  - Otherwise valid=0, command=0, write_data=0.
- Minimum latency: host handshake at edge N gives valid high after edge N+1.
- Strict in-order issue; no reordering and no bypass.
- A head blocked by a 0 pm bit stalls everything behind it, including commands to other banks.
- Back-to-back issue is allowed every cycle while conditions hold.
- Read tracking: each issued read pushes issue_tag_t {rank_num, bank_addr, row_addr, col_addr} into the tag FIFO on its issue edge.
  - read_data_valid at edge M with the tag FIFO not empty: pop; rsp_valid=1, rsp_data=read_data, rsp_tag=popped tag, all registered (1-cycle latency).
  - Tag FIFO empty at edge M: beat dropped, rsp_valid=0, rsp_err set until reset. A push at the same edge does not count; the pop sees registered state.
  - Push and pop at the same edge on a non-empty FIFO: both occur, occupancy unchanged.
  - When no beat arrives, rsp_data and rsp_tag hold their values; only rsp_valid drops.
- rd_outstanding tracks tag FIFO occupancy: +1 on issued read, -1 on a successful pop, net 0 when both occur.
- Pointers wrap modulo depth. Full/empty use one extra pointer bit.
- ba_cmd_pm bits for banks at or above 2^BA_BITS are ignored.

Decomposition:
- Package usertype (existing) holds user_command_type_t.
- Add issue_tag_t and the CQ_DEPTH/TAG_DEPTH defaults to that package.
- One sub-module, cmd_sync_fifo, parameterized for width and depth, with push/pop/full/empty/count, async active-high reset, and registered occupancy.
- It is instantiated twice: command+wdata queue of width CMD_W+DATA_W, and the tag FIFO.

Test Plan:
- Reset mid-operation: queue 3 writes with ba_cmd_pm=0, assert power_on_rst for 1 cycle → all outputs 0, then ba_cmd_pm=8'hFF → no valid ever appears.
- Single write to bank 0, row 5, col 8, wdata 128'hA5..A5, ba_cmd_pm=8'h01 → valid high exactly 1 cycle at N+1 with matching command and write_data.
- Head blocked: write to bank 2 then write to bank 0, ba_cmd_pm=8'h01 → nothing issues. Set bit 2 → both issue in order on consecutive cycles.
- Full queue: push 8 commands with ba_cmd_pm=0 → host_ready=0 after the 8th. The 9th host_valid is not accepted. Release → 8 issues, then host_ready=1.
- Reads: 16 reads row 0..15 col 0 → issue stalls at rd_outstanding=16. Return 16 beats → rsp_tag rows 0..15 in order, each with 1-cycle latency.
- Spurious read_data_valid with no read outstanding → rsp_err=1, rsp_valid stays 0, and rsp_err stays 1 until reset.
